ddr3_arbiter: RTL and testbench
===============================

Name: ddr3_arbiter

Overview:
Round-robin arbiter that shares the single-ported, cached DDR3 device (32-bit word interface, level rd/we, one-cycle ack) among N requesters: CPU instruction fetch, CPU data and the display/DMA engine.
Sits between the requesters and ddr3_dev.
At grant it latches the command, so the device always sees stable addr/data/op for the whole transaction.
Strobes drop the cycle after ack, so the device never starts a spurious second transaction.

Parameters:
N_PORTS, 3, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_rd_i  in  N_PORTS  per-port read request (level, held until ack)
req_we_i  in  N_PORTS  per-port write request (level, held until ack)
req_addr_i  in  N_PORTS*ADDR_W  per-port address, port k at [k*ADDR_W +: ADDR_W]
req_data_i  in  N_PORTS*DATA_W  per-port write data, same packing
req_ack_o  out  N_PORTS  one-cycle completion pulse to the granted port
req_data_o  out  DATA_W  read data, valid while any req_ack_o bit is high
mem_addr_o  out  ADDR_W  to ddr3_dev addr_i
mem_data_o  out  DATA_W  to ddr3_dev data_i
mem_rd_o  out  1  to ddr3_dev rd_i
mem_we_o  out  1  to ddr3_dev we_i
mem_data_i  in  DATA_W  from ddr3_dev data_o (valid while mem_ack_i)
mem_ack_i  in  1  from ddr3_dev ack_o
grant_o  out  N_PORTS  one-hot current owner (debug/display), 0 when idle

Behaviour:
- Reset: state IDLE, rr pointer 0, all outputs 0, latched addr/data 0. Reset mid-transaction abandons it; no ack is issued.
- A port is pending when req_rd_i[k] | req_we_i[k].
- If both bits are high on one port, the op is a read (mem_we_o = 0).
- State IDLE:
  - Pick the first pending port, searching from the rr pointer upward and wrapping at N_PORTS-1 -> 0.
  - If a port is found, register its addr, data and op into mem_*_o, set grant_o, set pointer = winner+1 (mod N_PORTS), go to BUSY.
  - If no port is pending, stay in IDLE.
- State BUSY:
  - Hold mem_*_o constant.
  - On mem_ack_i: capture mem_data_i into req_data_o, clear mem_rd_o/mem_we_o, go to RESP.
  - No timeout.
- State RESP (exactly one cycle):
  - req_ack_o[winner] = 1 and req_data_o valid; strobes stay 0.
  - Next state IDLE; grant_o clears on entering IDLE.
- Latency:
  - Request seen in IDLE at cycle T -> mem_rd_o high at T+1.
  - mem_ack_i at cycle A -> req_ack_o at A+1 -> IDLE at A+2.
  - Cached device hit (ack at T+2) gives req_ack_o at T+3.
- Request withdrawn during BUSY: the transaction still completes on the latched values and the ack pulse is still sent.
- mem_ack_i seen outside BUSY: ignored.
- Fairness: with all ports pending continuously, grants rotate 0,1,2,0,...; worst-case wait is N_PORTS-1 transactions.
- req_data_o holds its last captured value outside RESP.
- Write transactions also pulse ack; req_data_o content is don't-care for writes.

Optional Feature:
DDR3_ARB_PRIO_EN
- Defined: port 0 (display) has strict priority. If port 0 is pending in IDLE it wins regardless of the pointer, and the pointer is not updated. Ports 1..N-1 round-robin among themselves. Starvation of ports 1..N-1 is permitted.
- Undefined: pure round-robin over all ports, as above.

Decomposition:
- Header ddr3_arb.vh holds:
  - state encodings (S_IDLE=0, S_BUSY=1, S_RESP=2)
  - port index width via `GET_WIDTH(N_PORTS-1)
- Sub-module rr_picker: combinational, takes pending mask and pointer, returns winner index and valid flag. Instantiated once; reused by the PRIO path with port 0 masked out.

Test Plan:
- Single read, port 1, addr 0x0000_1040; device acks 2 cycles after mem_rd_o with data 0xDEAD_BEEF -> mem_addr_o = 0x0000_1040; req_ack_o = 3'b010 for one cycle with req_data_o = 0xDEAD_BEEF; mem_rd_o low in the ack cycle.
- All three ports request reads continuously for 6 transactions -> grant order 0,1,2,0,1,2; each req_ack_o is a single-cycle pulse; the device never sees back-to-back strobes without a low cycle.
- Port 2 write 0x1234_5678 @0x100 while port 0 drops its read mid-BUSY -> port 0 still gets its ack; then port 2 is granted with mem_we_o = 1, mem_data_o = 0x1234_5678.
- Port 0 asserts rd and we together -> mem_rd_o = 1, mem_we_o = 0.
- rst asserted in BUSY, then mem_ack_i arrives -> no req_ack_o pulse; all outputs 0; the next request is granted starting from port 0.
- With DDR3_ARB_PRIO_EN, port 0 pending every IDLE alongside ports 1 and 2 -> port 0 always granted. After port 0 stops, grants alternate 1,2.

Source files
------------

// File: rtl/ddr3_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ddr3_arbiter_pkg
// Shared types and helpers for the DDR3 requester arbiter:
//   state_e   - arbiter FSM encoding (IDLE=0, BUSY=1, RESP=2)
//   idx_width - bits needed to hold a port index 0..n-1 (minimum 1)
// ---------------------------------------------------------------------------
package ddr3_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Width of a port index able to address ports 0..n-1.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/ddr3_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// ddr3_arbiter_rr_picker
// Combinational round-robin search: returns the first set bit of pending_i,
// starting at ptr_i and wrapping from N_PORTS-1 back to 0.
// Ports:
//   pending_i [N_PORTS]  request mask to search
//   ptr_i     [IDX_W]    index where the search starts (must be < N_PORTS)
//   winner_o  [IDX_W]    index of the selected port (0 when none)
//   valid_o              a pending port was found
// ---------------------------------------------------------------------------
module ddr3_arbiter_rr_picker
    import ddr3_arbiter_pkg::*;
#(
    parameter  int unsigned N_PORTS = 3,
    localparam int unsigned IDX_W   = idx_width(N_PORTS)
) (
    input  logic [N_PORTS-1:0] pending_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               valid_o
);

    localparam int unsigned SUM_W = IDX_W + 1;

    logic [2*N_PORTS-1:0] pend_dbl;
    logic [N_PORTS-1:0]   pend_rot;
    logic [SUM_W-1:0]     sum;
    logic                 found;

    // Rotate the mask so bit 0 corresponds to the pointer position.
    assign pend_dbl = {pending_i, pending_i};
    assign pend_rot = N_PORTS'(pend_dbl >> ptr_i);

    // First set bit of the rotated mask, mapped back to an absolute index.
    always_comb begin
        found    = 1'b0;
        sum      = '0;
        winner_o = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (!found && pend_rot[i]) begin
                found = 1'b1;
                sum   = SUM_W'(ptr_i) + SUM_W'(i);
                if (sum >= SUM_W'(N_PORTS)) begin
                    sum = sum - SUM_W'(N_PORTS);
                end
                winner_o = IDX_W'(sum);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/ddr3_arbiter.sv
// ---------------------------------------------------------------------------
// ddr3_arbiter
// Round-robin arbiter sharing one single-ported DDR3 device (level rd/we,
// one-cycle ack) among N_PORTS requesters. The winning command is latched at
// grant so the device sees stable addr/data/op for the whole transaction, and
// the strobes drop in the cycle after ack so no second access is started.
//
// Optional feature (macro DDR3_ARB_PRIO_EN): port 0 gets strict priority and
// does not move the pointer; ports 1..N_PORTS-1 round-robin among themselves.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_rd_i/we_i  per-port level requests, held until ack
//   req_addr_i     per-port address, port k at [k*ADDR_W +: ADDR_W]
//   req_data_i     per-port write data, same packing
//   req_ack_o      one-cycle completion pulse to the granted port
//   req_data_o     read data, valid while any req_ack_o bit is high
//   mem_addr_o/mem_data_o/mem_rd_o/mem_we_o  command to the device
//   mem_data_i/mem_ack_i                     response from the device
//   grant_o        one-hot current owner, 0 when idle
// ---------------------------------------------------------------------------
module ddr3_arbiter
    import ddr3_arbiter_pkg::*;
#(
    parameter int unsigned N_PORTS = 3,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_PORTS-1:0]         req_rd_i,
    input  logic [N_PORTS-1:0]         req_we_i,
    input  logic [N_PORTS*ADDR_W-1:0]  req_addr_i,
    input  logic [N_PORTS*DATA_W-1:0]  req_data_i,
    output logic [N_PORTS-1:0]         req_ack_o,
    output logic [DATA_W-1:0]          req_data_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [DATA_W-1:0]          mem_data_o,
    output logic                       mem_rd_o,
    output logic                       mem_we_o,
    input  logic [DATA_W-1:0]          mem_data_i,
    input  logic                       mem_ack_i,
    output logic [N_PORTS-1:0]         grant_o
);

    localparam int unsigned IDX_W = idx_width(N_PORTS);

    state_e             state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   owner_q;
    logic [N_PORTS-1:0] grant_q;
    logic [N_PORTS-1:0] req_ack_q;
    logic [DATA_W-1:0]  req_data_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_data_q;
    logic               mem_rd_q;
    logic               mem_we_q;

    logic [N_PORTS-1:0] pending;
    logic [N_PORTS-1:0] pick_mask;
    logic               prio_hit;
    logic [IDX_W-1:0]   pick_winner;
    logic               pick_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_valid;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_rd;
    logic               sel_we;
    logic [IDX_W-1:0]   ptr_next;

    assign pending = req_rd_i | req_we_i;

    // Under priority mode port 0 bypasses the picker, which then only
    // rotates over the remaining ports.
`ifdef DDR3_ARB_PRIO_EN
    assign prio_hit  = pending[0];
    assign pick_mask = pending & ~N_PORTS'(1);
`else
    assign prio_hit  = 1'b0;
    assign pick_mask = pending;
`endif

    ddr3_arbiter_rr_picker #(
        .N_PORTS (N_PORTS)
    ) u_picker (
        .pending_i (pick_mask),
        .ptr_i     (ptr_q),
        .winner_o  (pick_winner),
        .valid_o   (pick_valid)
    );

    // Selected command; a port asserting both rd and we performs a read.
    assign sel_idx   = prio_hit ? '0 : pick_winner;
    assign sel_valid = prio_hit | pick_valid;
    assign sel_addr  = req_addr_i[32'(sel_idx)*ADDR_W +: ADDR_W];
    assign sel_data  = req_data_i[32'(sel_idx)*DATA_W +: DATA_W];
    assign sel_rd    = req_rd_i[sel_idx];
    assign sel_we    = req_we_i[sel_idx] & ~sel_rd;
    assign ptr_next  = (sel_idx == IDX_W'(N_PORTS - 1)) ? '0 : sel_idx + IDX_W'(1);

    // Arbiter FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            grant_q    <= '0;
            req_ack_q  <= '0;
            req_data_q <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_rd_q   <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            req_ack_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (sel_valid) begin
                        mem_addr_q <= sel_addr;
                        mem_data_q <= sel_data;
                        mem_rd_q   <= sel_rd;
                        mem_we_q   <= sel_we;
                        grant_q    <= N_PORTS'(1) << sel_idx;
                        owner_q    <= sel_idx;
                        // A priority win leaves the rotation where it was.
                        if (!prio_hit) begin
                            ptr_q <= ptr_next;
                        end
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (mem_ack_i) begin
                        req_data_q <= mem_data_i;
                        mem_rd_q   <= 1'b0;
                        mem_we_q   <= 1'b0;
                        req_ack_q  <= N_PORTS'(1) << owner_q;
                        state_q    <= S_RESP;
                    end
                end
                S_RESP: begin
                    grant_q <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    grant_q  <= '0;
                    mem_rd_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ack_o  = req_ack_q;
    assign req_data_o = req_data_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_data_o = mem_data_q;
    assign mem_rd_o   = mem_rd_q;
    assign mem_we_o   = mem_we_q;
    assign grant_o    = grant_q;

endmodule

// File: tb/tb_ddr3_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr3_arbiter
// Directed self-checking bench for ddr3_arbiter (N_PORTS=3, 32-bit buses).
// A small device model answers strobes with an ack after dev_lat cycles.
// ---------------------------------------------------------------------------
module tb_ddr3_arbiter;

    localparam int unsigned NP = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic              clk;
    logic              rst;
    logic [NP-1:0]     req_rd_i;
    logic [NP-1:0]     req_we_i;
    logic [NP*AW-1:0]  req_addr_i;
    logic [NP*DW-1:0]  req_data_i;
    logic [NP-1:0]     req_ack_o;
    logic [DW-1:0]     req_data_o;
    logic [AW-1:0]     mem_addr_o;
    logic [DW-1:0]     mem_data_o;
    logic              mem_rd_o;
    logic              mem_we_o;
    logic [DW-1:0]     mem_data_i;
    logic              mem_ack_i;
    logic [NP-1:0]     grant_o;

    int          errors = 0;
    int          checks = 0;
    int          dev_cnt = 0;
    int          dev_lat = 1;
    logic        dev_en = 1'b0;
    logic [31:0] dev_rdata = 32'h0;

    ddr3_arbiter #(
        .N_PORTS (NP),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_rd_i   (req_rd_i),
        .req_we_i   (req_we_i),
        .req_addr_i (req_addr_i),
        .req_data_i (req_data_i),
        .req_ack_o  (req_ack_o),
        .req_data_o (req_data_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_rd_o   (mem_rd_o),
        .mem_we_o   (mem_we_o),
        .mem_data_i (mem_data_i),
        .mem_ack_i  (mem_ack_i),
        .grant_o    (grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle, then let the device model react to the new outputs.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_ack_i) begin
            mem_ack_i = 1'b0;
            dev_cnt   = 0;
        end else if (dev_en && (mem_rd_o || mem_we_o)) begin
            dev_cnt++;
            if (dev_cnt > dev_lat) begin
                mem_ack_i  = 1'b1;
                mem_data_i = dev_rdata;
                dev_cnt    = 0;
            end
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_rd_i   = '0;
        req_we_i   = '0;
        req_addr_i = '0;
        req_data_i = '0;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        dev_cnt    = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({grant_o, req_ack_o, mem_rd_o, mem_we_o} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got grant=%b ack=%b rd=%b we=%b want all 0",
                     grant_o, req_ack_o, mem_rd_o, mem_we_o);
        end
        checks++;
        if ({mem_addr_o, mem_data_o, req_data_o} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h data=%h rdata=%h want 0",
                     mem_addr_o, mem_data_o, req_data_o);
        end
        tick();
        checks++;
        if (grant_o !== 3'b000 || mem_rd_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got grant=%b rd=%b want 000/0", grant_o, mem_rd_o);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        dev_en    = 1'b1;
        dev_lat   = 2;
        dev_rdata = 32'hDEAD_BEEF;
        req_addr_i[1*AW +: AW] = 32'h0000_1040;
        req_rd_i  = 3'b010;
        tick();
        checks++;
        if (mem_rd_o !== 1'b1 || mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL single_strobe: got rd=%b we=%b want 1/0", mem_rd_o, mem_we_o);
        end
        checks++;
        if (mem_addr_o !== 32'h0000_1040) begin
            errors++;
            $display("FAIL single_addr: got %h want 00001040", mem_addr_o);
        end
        checks++;
        if (grant_o !== 3'b010) begin
            errors++;
            $display("FAIL single_grant: got %b want 010", grant_o);
        end
        tick();
        tick();
        tick();
        checks++;
        if (req_ack_o !== 3'b010) begin
            errors++;
            $display("FAIL single_ack: got %b want 010", req_ack_o);
        end
        checks++;
        if (req_data_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_rdata: got %h want deadbeef", req_data_o);
        end
        checks++;
        if (mem_rd_o !== 1'b0) begin
            errors++;
            $display("FAIL single_rd_low: got %b want 0", mem_rd_o);
        end
        req_rd_i = '0;
        tick();
        checks++;
        if (req_ack_o !== 3'b000 || grant_o !== 3'b000) begin
            errors++;
            $display("FAIL single_after: got ack=%b grant=%b want 000/000", req_ack_o, grant_o);
        end
        checks++;
        if (req_data_o !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_hold: got %h want deadbeef", req_data_o);
        end
    endtask

    // Sequence of acks with all ports requesting; drop_at/drop_mask model a
    // port giving up after a given number of completions.
    task automatic run_sequence(input string name, input int n_txn, input int seq [8],
                                input int drop_at, input logic [NP-1:0] drop_mask);
        int            n = 0;
        int            cyc = 0;
        logic          was_ack;
        logic [NP-1:0] prev_ack = '0;
        logic [NP-1:0] exp;
        do_reset();
        dev_en  = 1'b1;
        dev_lat = 1;
        req_addr_i[0*AW +: AW] = 32'h0000_0000;
        req_addr_i[1*AW +: AW] = 32'h0000_0010;
        req_addr_i[2*AW +: AW] = 32'h0000_0020;
        req_rd_i = 3'b111;
        while (n < n_txn && cyc < 200) begin
            was_ack = mem_ack_i;
            tick();
            cyc++;
            if (was_ack) begin
                checks++;
                if (mem_rd_o || mem_we_o) begin
                    errors++;
                    $display("FAIL %s_gap: strobe rd=%b we=%b in cycle after ack", name, mem_rd_o, mem_we_o);
                end
            end
            if (prev_ack != '0) begin
                checks++;
                if (req_ack_o !== 3'b000) begin
                    errors++;
                    $display("FAIL %s_pulse: got ack=%b want 000 after pulse", name, req_ack_o);
                end
            end
            if (req_ack_o != '0) begin
                exp = 3'b001 << seq[n];
                checks++;
                if (req_ack_o !== exp) begin
                    errors++;
                    $display("FAIL %s_order: txn %0d got ack=%b want %b", name, n, req_ack_o, exp);
                end
                n++;
                if (n == drop_at) req_rd_i = req_rd_i & ~drop_mask;
                if (n == n_txn) req_rd_i = '0;
            end
            prev_ack = req_ack_o;
        end
        checks++;
        if (n != n_txn) begin
            errors++;
            $display("FAIL %s_count: got %0d acks want %0d", name, n, n_txn);
        end
        tick();
        checks++;
        if (req_ack_o !== 3'b000 || grant_o !== 3'b000) begin
            errors++;
            $display("FAIL %s_end: got ack=%b grant=%b want 000/000", name, req_ack_o, grant_o);
        end
    endtask

    task automatic test_withdraw();
        int cnt;
        do_reset();
        dev_en  = 1'b1;
        dev_lat = 2;
        req_addr_i[0*AW +: AW] = 32'h0000_0040;
        req_addr_i[2*AW +: AW] = 32'h0000_0100;
        req_data_i[2*DW +: DW] = 32'h1234_5678;
        req_rd_i = 3'b001;
        req_we_i = 3'b100;
        tick();
        checks++;
        if (grant_o !== 3'b001 || mem_rd_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h40) begin
            errors++;
            $display("FAIL wd_grant0: got grant=%b rd=%b we=%b addr=%h want 001/1/0/00000040",
                     grant_o, mem_rd_o, mem_we_o, mem_addr_o);
        end
        req_rd_i = 3'b000;
        tick();
        checks++;
        if (mem_rd_o !== 1'b1 || mem_addr_o !== 32'h40) begin
            errors++;
            $display("FAIL wd_hold: got rd=%b addr=%h want 1/00000040", mem_rd_o, mem_addr_o);
        end
        cnt = 0;
        while (req_ack_o == '0 && cnt < 20) begin
            tick();
            cnt++;
        end
        checks++;
        if (req_ack_o !== 3'b001) begin
            errors++;
            $display("FAIL wd_ack0: got %b want 001", req_ack_o);
        end
        cnt = 0;
        while (!mem_we_o && cnt < 10) begin
            tick();
            cnt++;
        end
        checks++;
        if (grant_o !== 3'b100 || mem_we_o !== 1'b1 || mem_rd_o !== 1'b0) begin
            errors++;
            $display("FAIL wd_grant2: got grant=%b we=%b rd=%b want 100/1/0", grant_o, mem_we_o, mem_rd_o);
        end
        checks++;
        if (mem_data_o !== 32'h1234_5678 || mem_addr_o !== 32'h0000_0100) begin
            errors++;
            $display("FAIL wd_wcmd: got data=%h addr=%h want 12345678/00000100", mem_data_o, mem_addr_o);
        end
        cnt = 0;
        while (req_ack_o == '0 && cnt < 20) begin
            tick();
            cnt++;
        end
        checks++;
        if (req_ack_o !== 3'b100) begin
            errors++;
            $display("FAIL wd_ack2: got %b want 100", req_ack_o);
        end
        req_we_i = '0;
        tick();
    endtask

    task automatic test_rd_we();
        int cnt;
        do_reset();
        dev_en  = 1'b1;
        dev_lat = 1;
        req_addr_i[0*AW +: AW] = 32'h0000_0080;
        req_rd_i = 3'b001;
        req_we_i = 3'b001;
        tick();
        checks++;
        if (mem_rd_o !== 1'b1 || mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL rdwe_op: got rd=%b we=%b want 1/0", mem_rd_o, mem_we_o);
        end
        cnt = 0;
        while (req_ack_o == '0 && cnt < 20) begin
            tick();
            cnt++;
        end
        checks++;
        if (req_ack_o !== 3'b001) begin
            errors++;
            $display("FAIL rdwe_ack: got %b want 001", req_ack_o);
        end
        req_rd_i = '0;
        req_we_i = '0;
        tick();
    endtask

    task automatic test_reset_busy();
        int cnt;
        do_reset();
        dev_en = 1'b0;
        req_addr_i[1*AW +: AW] = 32'h0000_0200;
        req_rd_i = 3'b010;
        tick();
        checks++;
        if (grant_o !== 3'b010 || mem_rd_o !== 1'b1) begin
            errors++;
            $display("FAIL rb_busy: got grant=%b rd=%b want 010/1", grant_o, mem_rd_o);
        end
        rst      = 1'b1;
        req_rd_i = '0;
        tick();
        checks++;
        if ({grant_o, req_ack_o, mem_rd_o, mem_we_o} !== 8'h00 || mem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL rb_reset: got grant=%b ack=%b rd=%b we=%b addr=%h want all 0",
                     grant_o, req_ack_o, mem_rd_o, mem_we_o, mem_addr_o);
        end
        rst        = 1'b0;
        mem_ack_i  = 1'b1;
        mem_data_i = 32'hCAFE_F00D;
        tick();
        checks++;
        if (req_ack_o !== 3'b000 || req_data_o !== 32'h0) begin
            errors++;
            $display("FAIL rb_stray_ack: got ack=%b rdata=%h want 000/00000000", req_ack_o, req_data_o);
        end
        checks++;
        if (grant_o !== 3'b000 || mem_rd_o !== 1'b0) begin
            errors++;
            $display("FAIL rb_idle: got grant=%b rd=%b want 000/0", grant_o, mem_rd_o);
        end
        req_rd_i = 3'b101;
        tick();
        checks++;
        if (grant_o !== 3'b001) begin
            errors++;
            $display("FAIL rb_ptr0: got grant=%b want 001", grant_o);
        end
        dev_en  = 1'b1;
        dev_lat = 1;
        cnt = 0;
        while (req_ack_o == '0 && cnt < 20) begin
            tick();
            cnt++;
        end
        checks++;
        if (req_ack_o !== 3'b001) begin
            errors++;
            $display("FAIL rb_ack0: got %b want 001", req_ack_o);
        end
        req_rd_i = '0;
        tick();
        tick();
    endtask

    initial begin
        int rot_seq [8]  = '{0, 1, 2, 0, 1, 2, 0, 0};
        int prio_seq [8] = '{0, 0, 0, 1, 2, 1, 2, 0};
        test_reset();
        test_single_read();
`ifdef DDR3_ARB_PRIO_EN
        run_sequence("prio", 7, prio_seq, 3, 3'b001);
`else
        run_sequence("rotate", 6, rot_seq, 0, 3'b000);
`endif
        test_withdraw();
        test_rd_we();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
